// File: rtl/eth_sim_pkg.sv
// Shared AXIS widths, checker states and backpressure LFSR helpers for the 10G loopback sim.
package eth_sim_pkg;
  localparam int AXIS_DW = 64;
  localparam int AXIS_KW = 8;
  localparam logic [AXIS_KW-1:0] KEEP_ALL = 8'hFF;
  localparam logic [AXIS_DW-1:0] DEFAULT_PATTERN = 64'h0011223344556677;
  // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {IDLE, BODY, OVERRUN} chk_state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/axis_bp_lfsr.sv
// Registered tready source: always ready, or ~75% duty pseudo-random backpressure.
module axis_bp_lfsr
  import eth_sim_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic clk156,
  input  logic rst,
  input  logic enable,
  output logic ready
);
  logic [15:0] lfsr;

  // LFSR free-runs so the pattern does not depend on when bp_enable toggles
  always_ff @(posedge clk156) begin
    if (rst) begin
      lfsr  <= SEED;
      ready <= 1'b0;
    end else begin
      lfsr  <= lfsr_next(lfsr);
      ready <= enable ? (lfsr[0] | lfsr[1]) : 1'b1;
    end
  end
endmodule

// File: rtl/eth_frame_checker.sv
// Receive-side AXIS frame checker: classifies fixed-length pattern frames, keeps stats and sticky errors.
module eth_frame_checker
  import eth_sim_pkg::*;
#(
  parameter int                 FRAME_BEATS  = 5,
  parameter logic [AXIS_DW-1:0] DATA_PATTERN = DEFAULT_PATTERN,
  parameter int                 CNT_W        = 32,
  parameter logic [15:0]        LFSR_SEED    = 16'hACE1
) (
  input  logic               clk156,
  input  logic               rst,
  output logic               s_axis_rx_tready,
  input  logic               s_axis_rx_tvalid,
  input  logic [AXIS_DW-1:0] s_axis_rx_tdata,
  input  logic [AXIS_KW-1:0] s_axis_rx_tkeep,
  input  logic               s_axis_rx_tlast,
  input  logic               s_axis_rx_tuser,
  input  logic               bp_enable,
  input  logic               clear_stats,
  output logic               frame_done,
  output logic               frame_ok,
  output logic [CNT_W-1:0]   good_frames,
  output logic [CNT_W-1:0]   bad_frames,
  output logic               err_data,
  output logic               err_len,
  output logic               err_user
);
  localparam int IDX_W = $clog2(FRAME_BEATS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BEATS - 1);

  chk_state_t     state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic           data_bad, user_bad, len_bad;
  logic           acc_data, acc_user, acc_len;
  logic           accept, beat_data, close;

  axis_bp_lfsr #(.SEED(LFSR_SEED)) u_bp (
    .clk156 (clk156),
    .rst    (rst),
    .enable (bp_enable),
    .ready  (s_axis_rx_tready)
  );

  assign accept    = s_axis_rx_tvalid & s_axis_rx_tready;
  assign beat_data = (s_axis_rx_tdata != DATA_PATTERN) || (s_axis_rx_tkeep != KEEP_ALL);

  // acc_* are the frame flags including the current beat; they feed both the
  // running flags and the close-time classification.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    acc_data = data_bad;
    acc_user = user_bad;
    acc_len  = len_bad;
    close    = 1'b0;
    if (accept) begin
      unique case (state)
        IDLE: begin
          acc_data = beat_data;
          acc_user = s_axis_rx_tuser;
          acc_len  = s_axis_rx_tlast;
          idx_n    = IDX_W'(1);
          if (s_axis_rx_tlast) begin
            close = 1'b1;
            idx_n = '0;
          end else begin
            state_n = BODY;
          end
        end
        BODY: begin
          acc_data = data_bad | beat_data;
          acc_user = user_bad | s_axis_rx_tuser;
          idx_n    = idx + IDX_W'(1);
          if (s_axis_rx_tlast) begin
            acc_len = len_bad | (idx < LAST_IDX);
            close   = 1'b1;
            idx_n   = '0;
            state_n = IDLE;
          end else if (idx == LAST_IDX) begin
            acc_len = 1'b1;
            state_n = OVERRUN;
          end
        end
        OVERRUN: begin
          acc_data = data_bad | beat_data;
          acc_user = user_bad | s_axis_rx_tuser;
          if (s_axis_rx_tlast) begin
            close   = 1'b1;
            idx_n   = '0;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk156) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      data_bad <= 1'b0;
      user_bad <= 1'b0;
      len_bad  <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      data_bad <= acc_data;
      user_bad <= acc_user;
      len_bad  <= acc_len;
    end
  end

  // Stats: a coincident clear beats the closing frame, but the pulse still fires.
  always_ff @(posedge clk156) begin
    if (rst) begin
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      good_frames <= '0;
      bad_frames  <= '0;
      err_data    <= 1'b0;
      err_len     <= 1'b0;
      err_user    <= 1'b0;
    end else begin
      frame_done <= close;
      frame_ok   <= close & ~(acc_data | acc_len | acc_user);
      if (clear_stats) begin
        good_frames <= '0;
        bad_frames  <= '0;
        err_data    <= 1'b0;
        err_len     <= 1'b0;
        err_user    <= 1'b0;
      end else if (close) begin
        if (!(acc_data | acc_len | acc_user)) begin
          if (good_frames != '1) good_frames <= good_frames + CNT_W'(1);
        end else begin
          if (bad_frames != '1) bad_frames <= bad_frames + CNT_W'(1);
        end
        err_data <= err_data | acc_data;
        err_len  <= err_len  | acc_len;
        err_user <= err_user | acc_user;
      end
    end
  end
endmodule
